// File: rtl/lifo_pkg.sv
// Shared types and default widths for the LIFO read-side controller.
package lifo_pkg;

   localparam int LIFO_DWIDTH = 8;
   localparam int LIFO_AWIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_POP   = 2'd1,
      ST_DRAIN = 2'd2
   } lifo_rd_state_t;

endpackage

// File: rtl/lifo_rd_skid.sv
// Two-entry first-in first-out buffer that absorbs the LIFO read latency
// and presents the popped words as a valid/ready stream.
module lifo_rd_skid
   import lifo_pkg::*;
#(
   parameter int DWIDTH = LIFO_DWIDTH
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              wr_en_i,
   input  logic [DWIDTH-1:0] wr_data_i,
   input  logic              ready_i,
   output logic [DWIDTH-1:0] data_o,
   output logic              valid_o,
   output logic [1:0]        buf_cnt_o
);

   logic [DWIDTH-1:0] ent0_q, ent0_d;
   logic [DWIDTH-1:0] ent1_q, ent1_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              pop;

   assign valid_o   = (cnt_q != 2'd0) && !srst_i;
   assign pop       = valid_o && ready_i;
   assign data_o    = ent0_q;
   assign buf_cnt_o = cnt_q;

   // Entry 0 is always the head; a pop shifts entry 1 down before any write lands.
   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      cnt_d  = cnt_q;
      if (pop) begin
         ent0_d = ent1_q;
         cnt_d  = cnt_q - 2'd1;
      end
      if (wr_en_i) begin
         if (cnt_d == 2'd0) begin
            ent0_d = wr_data_i;
         end else begin
            ent1_d = wr_data_i;
         end
         cnt_d = cnt_d + 2'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         ent0_q <= '0;
         ent1_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/lifo_reader.sv
// Burst read controller for the lifo stack: pops N words without ever
// popping an empty stack and streams them out with last on the final beat.
module lifo_reader
   import lifo_pkg::*;
#(
   parameter int DWIDTH = LIFO_DWIDTH,
   parameter int AWIDTH = LIFO_AWIDTH
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              cmd_valid_i,
   input  logic [AWIDTH:0]   cmd_len_i,
   output logic              cmd_ready_o,
   output logic              lifo_rdreq_o,
   input  logic [DWIDTH-1:0] lifo_q_i,
   input  logic              lifo_empty_i,
   output logic [DWIDTH-1:0] data_o,
   output logic              valid_o,
   output logic              last_o,
   input  logic              ready_i,
   output logic              busy_o,
   output lifo_rd_state_t    state_o
);

   localparam int CW = AWIDTH + 1;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   lifo_rd_state_t  state_q, state_d;
   logic [CW-1:0]   issue_cnt_q, issue_cnt_d;
   logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
   logic            inflight_q, inflight_d;
   logic [1:0]      buf_cnt;
   logic [2:0]      occ;
   logic            hs;
   logic            accept;

   lifo_rd_skid #(.DWIDTH(DWIDTH)) u_skid (
      .clk_i     (clk_i),
      .srst_i    (srst_i),
      .wr_en_i   (inflight_q),
      .wr_data_i (lifo_q_i),
      .ready_i   (ready_i),
      .data_o    (data_o),
      .valid_o   (valid_o),
      .buf_cnt_o (buf_cnt)
   );

   assign hs     = valid_o && ready_i;
   // Slots still committed after this edge; a pop is only safe if one stays free.
   assign occ    = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, hs};
   assign accept = cmd_valid_i && cmd_ready_o;

   assign cmd_ready_o  = (state_q == ST_IDLE) && !srst_i;
   assign busy_o       = (state_q != ST_IDLE) && !srst_i;
   assign lifo_rdreq_o = (state_q == ST_POP) && !srst_i && !lifo_empty_i &&
                         (issue_cnt_q != '0) && (occ < 3'd2);
   assign last_o       = valid_o && (beat_cnt_q == CNT_ONE);
   assign state_o      = state_q;

   always_comb begin
      state_d     = state_q;
      issue_cnt_d = issue_cnt_q;
      beat_cnt_d  = beat_cnt_q;
      inflight_d  = lifo_rdreq_o;
      if (hs && beat_cnt_q != '0) begin
         beat_cnt_d = beat_cnt_q - CNT_ONE;
      end
      if (lifo_rdreq_o) begin
         issue_cnt_d = issue_cnt_q - CNT_ONE;
      end
      case (state_q)
         ST_IDLE: begin
            if (accept && cmd_len_i != '0) begin
               state_d     = ST_POP;
               issue_cnt_d = cmd_len_i;
               beat_cnt_d  = cmd_len_i;
            end
         end
         ST_POP: begin
            if (lifo_rdreq_o && issue_cnt_q == CNT_ONE) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (last_o && ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q     <= ST_IDLE;
         issue_cnt_q <= '0;
         beat_cnt_q  <= '0;
         inflight_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         beat_cnt_q  <= beat_cnt_d;
         inflight_q  <= inflight_d;
      end
   end

endmodule

// File: tb/tb_lifo_reader.sv
// Bench for lifo_reader: a queue-based LIFO model feeds the read port and a
// scoreboard of popped words checks every stream beat.
module tb_lifo_reader;
   import lifo_pkg::*;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int CW    = AW + 1;
   localparam int DEPTH = 16;

   logic           clk_i = 1'b0;
   logic           srst_i = 1'b1;
   logic           cmd_valid_i = 1'b0;
   logic [CW-1:0]  cmd_len_i = '0;
   logic           cmd_ready_o;
   logic           lifo_rdreq_o;
   logic [DW-1:0]  lifo_q_i = '0;
   logic           lifo_empty_i = 1'b1;
   logic [DW-1:0]  data_o;
   logic           valid_o;
   logic           last_o;
   logic           ready_i = 1'b0;
   logic           busy_o;
   lifo_rd_state_t state_o;

   always #5 clk_i = ~clk_i;

   lifo_reader #(.DWIDTH(DW), .AWIDTH(AW)) dut (
      .clk_i        (clk_i),
      .srst_i       (srst_i),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_len_i    (cmd_len_i),
      .cmd_ready_o  (cmd_ready_o),
      .lifo_rdreq_o (lifo_rdreq_o),
      .lifo_q_i     (lifo_q_i),
      .lifo_empty_i (lifo_empty_i),
      .data_o       (data_o),
      .valid_o      (valid_o),
      .last_o       (last_o),
      .ready_i      (ready_i),
      .busy_o       (busy_o),
      .state_o      (state_o)
   );

   typedef struct {
      int preload;
      int len;
      int ready_pct;
      int wr_n;
   } vec_t;

   int            errors = 0;
   int            checks = 0;
   logic [DW-1:0] stack[$];
   logic [DW-1:0] exp_q[$];
   int            beats_left = 0;
   int            occ = 0;
   bit            exp_busy = 0;
   bit            accepted = 0;
   int            tick_no = 0;
   int            hs_count = 0;
   int            first_valid_tick = -1;
   int            last_hs_tick = 0;
   int            accept_tick = 0;
   int            wr_left = 0;
   int            writes_done = 0;
   bit            hold_prev = 0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: sample and check at negedge, update the model at posedge.
   task automatic tick();
      bit            s_rdreq, s_hs, do_pop, do_push, acc_now;
      logic [DW-1:0] popped, push_val;
      int            s_len;
      popped   = '0;
      acc_now  = 0;
      s_rdreq  = 0;
      s_hs     = 0;
      @(negedge clk_i);
      if (srst_i) begin
         check("rst_cmd_ready", cmd_ready_o, 0);
         check("rst_rdreq", lifo_rdreq_o, 0);
         check("rst_valid", valid_o, 0);
         check("rst_last", last_o, 0);
         check("rst_busy", busy_o, 0);
      end else begin
         check("pop_when_empty", lifo_rdreq_o && lifo_empty_i, 0);
         check("busy", busy_o, exp_busy);
         check("cmd_ready", cmd_ready_o, !exp_busy);
         if (hold_prev) begin
            check("hold_valid", valid_o, 1);
            check("hold_data", data_o, prev_data);
            check("hold_last", last_o, prev_last);
         end
         if (valid_o) begin
            check("beat_available", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("beat_data", data_o, exp_q[0]);
            check("beat_last", last_o, beats_left == 1);
            if (first_valid_tick < 0) first_valid_tick = tick_no;
         end else begin
            check("last_without_valid", last_o, 0);
         end
         s_rdreq = lifo_rdreq_o;
         s_hs    = valid_o && ready_i;
         acc_now = cmd_valid_i && cmd_ready_o;
      end
      accepted  = acc_now;
      s_len     = int'(cmd_len_i);
      hold_prev = valid_o && !ready_i && !srst_i;
      prev_data = data_o;
      prev_last = last_o;
      do_pop    = s_rdreq && stack.size() != 0;
      do_push   = !srst_i && wr_left > 0 && stack.size() < DEPTH;
      push_val  = DW'($urandom);
      @(posedge clk_i);
      if (srst_i) begin
         exp_q.delete();
         stack.delete();
         beats_left = 0;
         occ        = 0;
         exp_busy   = 0;
         hold_prev  = 0;
         wr_left    = 0;
      end else begin
         if (do_pop) begin
            popped = stack.pop_back();
            exp_q.push_back(popped);
         end
         if (do_push) begin
            stack.push_back(push_val);
            wr_left--;
            writes_done++;
         end
         if (s_hs) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            hs_count++;
            last_hs_tick = tick_no;
            if (beats_left > 0) beats_left--;
            if (beats_left == 0) exp_busy = 0;
         end
         if (acc_now) begin
            beats_left  = s_len;
            exp_busy    = (s_len != 0);
            accept_tick = tick_no;
         end
         occ = occ + int'(s_rdreq) - int'(s_hs);
         check("occupancy_le_2", occ <= 2, 1);
      end
      tick_no++;
      #1;
      lifo_empty_i = (stack.size() == 0);
      lifo_q_i     = do_pop ? popped : DW'($urandom);
   endtask

   task automatic apply_reset();
      srst_i = 1'b1;
      cmd_valid_i = 1'b0;
      repeat (2) tick();
      srst_i = 1'b0;
   endtask

   task automatic run_vec(input int preload, input int len, input int ready_pct,
                          input int wr_n, input string name);
      int budget;
      stack.delete();
      for (int i = 0; i < preload; i++) stack.push_back(DW'(i + 1));
      lifo_empty_i     = (stack.size() == 0);
      writes_done      = 0;
      hs_count         = 0;
      first_valid_tick = -1;
      cmd_valid_i      = 1'b1;
      cmd_len_i        = CW'(len);
      budget           = 0;
      do begin
         ready_i = ($urandom_range(1, 100) <= ready_pct);
         tick();
         budget++;
      end while (!accepted && budget < 8);
      cmd_valid_i = 1'b0;
      check({name, "_accepted"}, accepted, 1);
      wr_left = wr_n;
      budget  = 0;
      while ((exp_busy || exp_q.size() != 0 || wr_left > 0) && budget < 400) begin
         ready_i = ($urandom_range(1, 100) <= ready_pct);
         tick();
         budget++;
      end
      check({name, "_no_timeout"}, budget < 400, 1);
      ready_i = 1'b1;
      repeat (3) tick();
      check({name, "_usedw"}, stack.size(), preload + writes_done - len);
      check({name, "_beats"}, hs_count, len);
      if (ready_pct == 100 && wr_n == 0 && len > 0 && preload >= len) begin
         check({name, "_latency"}, first_valid_tick - accept_tick, 3);
         check({name, "_consecutive"}, last_hs_tick - first_valid_tick, len - 1);
      end
      if (budget >= 400) apply_reset();
   endtask

   vec_t vecs[12];

   initial begin
      int budget;
      vecs[0] = '{5, 5, 100, 0};
      vecs[1] = '{16, 16, 50, 0};
      vecs[2] = '{0, 3, 100, 3};
      vecs[3] = '{0, 0, 100, 0};
      vecs[4] = '{4, 0, 100, 0};
      vecs[5] = '{3, 7, 80, 5};
      vecs[6] = '{1, 1, 100, 0};
      for (int i = 7; i < 12; i++) begin
         vecs[i].preload   = $urandom_range(0, 12);
         vecs[i].wr_n      = $urandom_range(0, 4);
         vecs[i].len       = $urandom_range(0, vecs[i].preload + vecs[i].wr_n);
         vecs[i].ready_pct = $urandom_range(20, 100);
      end

      repeat (3) tick();
      srst_i = 1'b0;
      tick();

      for (int i = 0; i < 12; i++) begin
         run_vec(vecs[i].preload, vecs[i].len, vecs[i].ready_pct, vecs[i].wr_n,
                 $sformatf("vec%0d", i));
      end

      // Reset in the middle of an 8-word burst, after the third beat.
      stack.delete();
      for (int i = 0; i < 10; i++) stack.push_back(DW'(8'h40 + i));
      lifo_empty_i = 1'b0;
      hs_count     = 0;
      ready_i      = 1'b1;
      cmd_valid_i  = 1'b1;
      cmd_len_i    = CW'(8);
      tick();
      cmd_valid_i = 1'b0;
      check("midrst_accepted", accepted, 1);
      budget = 0;
      while (hs_count < 3 && budget < 40) begin
         tick();
         budget++;
      end
      check("midrst_three_beats", hs_count, 3);
      apply_reset();
      tick();
      check("midrst_ready_after", cmd_ready_o, 1);
      run_vec(4, 4, 100, 0, "post_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
